display_scan_ctrl: RTL and testbench

Parametrised ping-pong display scan controller that replaces the fixed 3-colour, 10-bit sequencer.
- Walks each frame as vertical blank, then horizontal blank, then active pixels, emitting one channel slot per clock.
- Drives read enable and address into the front buffer while granting write to the back buffer.
- Swaps buffers at frame end only when the writer has signalled that the back buffer is full.
- Sits between the frame-buffer pair and the colour mux / sync outputs.

---
 rtl/display_scan_if.sv | 27 ++
 rtl/display_scan_ctrl.sv | 95 +++++++++
 tb/tb_display_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// display_scan_if: timing config, buffer handshake and scan outputs of the display scan controller
interface display_scan_if #(
  parameter int CW = 10,
  parameter int NCH = 3,
  parameter int ADDR_W = 17
);
  logic cs_display;
  logic [CW-1:0] hb_len, vb_len, act_px, act_ln;
  logic back_full;
  logic busy, blank;
  logic [NCH-1:0] chan_sel;
  logic buf_sel, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0] wr_en;
  logic sync_hb, sync_vb, buf_swap, frame_done;
  logic [7:0] underrun_cnt;
  modport master (
    input cs_display, hb_len, vb_len, act_px, act_ln, back_full,
    output busy, blank, chan_sel, buf_sel, rd_en, rd_addr, wr_en,
    output sync_hb, sync_vb, buf_swap, frame_done, underrun_cnt
  );
  modport slave (
    output cs_display, hb_len, vb_len, act_px, act_ln, back_full,
    input busy, blank, chan_sel, buf_sel, rd_en, rd_addr, wr_en,
    input sync_hb, sync_vb, buf_swap, frame_done, underrun_cnt
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: ping-pong frame-buffer scan sequencer; define UNDERRUN_CNT_EN to build the underrun counter
module display_scan_ctrl #(
  parameter int CW = 10,
  parameter int NCH = 3,
  parameter int ADDR_W = 17
) (
  input logic clk,
  input logic reset,
  display_scan_if.master bus
);
  localparam int SW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int W = CW + 1;
  typedef enum logic [1:0] {IDLE, VBLANK, HBLANK, ACTIVE} state_t;
  state_t state;
  logic [SW-1:0] slot;
  logic [W-1:0] px, ln, nx_px, nx_ln, sum_ln, sum_px, n_lines, line_len;
  logic [CW-1:0] hb_s, vb_s, ap_s, al_s;
  logic [ADDR_W-1:0] rd_addr;
  logic buf_sel, swap, last_slot, last_px, last_ln, frame_end;
  function automatic state_t region(input logic [W-1:0] l, p, input logic [CW-1:0] vb, hb, ap, al);
    return (l < W'(vb) || l >= W'(vb) + W'(al)) ? VBLANK :
           (p < W'(hb) || p >= W'(hb) + W'(ap)) ? HBLANK : ACTIVE;
  endfunction
  assign sum_ln = W'(vb_s) + W'(al_s);
  assign sum_px = W'(hb_s) + W'(ap_s);
  assign n_lines = (sum_ln == '0) ? W'(1) : sum_ln;
  assign line_len = (sum_ln == '0 || sum_px == '0) ? W'(1) : sum_px;
  assign last_slot = slot == SW'(NCH - 1);
  assign last_px = px == line_len - W'(1);
  assign last_ln = ln == n_lines - W'(1);
  assign frame_end = (state != IDLE) && last_slot && last_px && last_ln;
  assign nx_px = last_px ? '0 : px + W'(1);
  assign nx_ln = last_px ? ln + W'(1) : ln;
  // frame walker: shadow config, slot/pixel/line counters, region state and buffer swap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      px <= '0;
      ln <= '0;
      rd_addr <= '0;
      buf_sel <= 1'b0;
      swap <= 1'b0;
      hb_s <= '0;
      vb_s <= '0;
      ap_s <= '0;
      al_s <= '0;
    end else if (state == IDLE || frame_end) begin
      slot <= '0;
      px <= '0;
      ln <= '0;
      rd_addr <= '0;
      swap <= frame_end && bus.back_full;
      buf_sel <= buf_sel ^ (frame_end && bus.back_full);
      if (bus.cs_display) begin
        hb_s <= bus.hb_len;
        vb_s <= bus.vb_len;
        ap_s <= bus.act_px;
        al_s <= bus.act_ln;
        state <= region('0, '0, bus.vb_len, bus.hb_len, bus.act_px, bus.act_ln);
      end else begin
        state <= IDLE;
      end
    end else begin
      swap <= 1'b0;
      slot <= last_slot ? '0 : slot + SW'(1);
      rd_addr <= rd_addr + ADDR_W'(state == ACTIVE && last_slot);
      if (last_slot) begin
        px <= nx_px;
        ln <= nx_ln;
        state <= region(nx_ln, nx_px, vb_s, hb_s, ap_s, al_s);
      end
    end
  assign bus.busy = state != IDLE;
  assign bus.blank = state == VBLANK || state == HBLANK;
  assign bus.chan_sel = (state == IDLE) ? '0 : NCH'(1) << slot;
  assign bus.buf_sel = buf_sel;
  assign bus.wr_en = buf_sel ? 2'b01 : 2'b10;
  assign bus.rd_en = state == ACTIVE;
  assign bus.rd_addr = rd_addr;
  assign bus.sync_hb = state != IDLE && slot == '0 && px == '0;
  assign bus.sync_vb = state != IDLE && slot == '0 && px == '0 && ln == '0;
  assign bus.buf_swap = swap;
  assign bus.frame_done = frame_end;
`ifdef UNDERRUN_CNT_EN
  logic [7:0] urun;
  // saturating count of frame ends that found the back buffer incomplete
  always_ff @(posedge clk or posedge reset)
    if (reset) urun <= '0;
    else if (frame_end && !bus.back_full && urun != 8'hff) urun <= urun + 8'd1;
  assign bus.underrun_cnt = urun;
`else
  assign bus.underrun_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table vectors, scripted corner sequences and randomized frames against a frame-arithmetic model
module tb_display_scan_ctrl;
  localparam int CW = 10;
  localparam int NCH = 3;
  localparam int AW = 17;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  display_scan_if #(.CW(CW), .NCH(NCH), .ADDR_W(AW)) bus ();
  display_scan_ctrl #(.CW(CW), .NCH(NCH), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {int hb; int vb; int ap; int al; int len; int rd;} vec_t;
  vec_t vt[7];
  int tests = 0;
  int fails = 0;
  bit mb, swp;
  logic [7:0] ur;
  logic [37:0] act;
  assign act = {bus.busy, bus.blank, bus.chan_sel, bus.buf_sel, bus.rd_en, bus.rd_addr, bus.wr_en,
                bus.sync_hb, bus.sync_vb, bus.buf_swap, bus.frame_done, bus.underrun_cnt};
  function automatic logic [37:0] pk(bit busy, bit blank, logic [2:0] ch, bit bs, bit re, logic [16:0] ra,
                                     bit shb, bit svb, bit sw, bit fd, logic [7:0] u);
    return {busy, blank, ch, bs, re, ra, bs ? 2'b01 : 2'b10, shb, svb, sw, fd, u};
  endfunction
  task automatic chk(input string nm, input logic [37:0] exp, input logic [37:0] got);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic chkv(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic idle_chk(input string nm);
    chk(nm, pk(0, 0, 3'd0, mb, 0, 17'd0, 0, 0, swp, 0, ur), act);
  endtask
  task automatic to_idle(input string nm);
    @(negedge clk);
    idle_chk(nm);
    swp = 0;
    @(negedge clk);
    idle_chk({nm, "_hold"});
  endtask
  // call at a negedge just before the edge that starts the frame
  task automatic frame(input vec_t c, input bit bf, input bit cont, output int len, output int rds);
    int nl, lp, lines, ll, total, pix, s, ln, p, ab;
    bit a;
    logic [37:0] e;
    bus.hb_len = CW'(c.hb);
    bus.vb_len = CW'(c.vb);
    bus.act_px = CW'(c.ap);
    bus.act_ln = CW'(c.al);
    bus.cs_display = 1'b1;
    nl = c.vb + c.al;
    lp = c.hb + c.ap;
    lines = (nl == 0) ? 1 : nl;
    ll = (nl == 0 || lp == 0) ? 1 : lp;
    total = lines * ll * NCH;
    len = 0;
    rds = 0;
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      pix = t / NCH;
      s = t % NCH;
      ln = pix / ll;
      p = pix % ll;
      a = ln >= c.vb && ln < nl && p >= c.hb && p < lp;
      ab = (ln > c.vb) ? ln - c.vb : 0;
      e = pk(1, !a, 3'(1 << s), mb, a, 17'(ab * c.ap + (a ? p - c.hb : 0)),
             s == 0 && p == 0, t == 0, t == 0 && swp, t == total - 1, ur);
      chk($sformatf("frame hb%0d vb%0d ap%0d al%0d t=%0d", c.hb, c.vb, c.ap, c.al, t), e, act);
      if (bus.frame_done && len == 0) len = t + 1;
      rds += int'(bus.rd_en);
      if (t == total - 1) begin
        bus.cs_display = cont;
        bus.back_full = bf;
      end else begin
        bus.cs_display = 1'($urandom);
        bus.back_full = 1'($urandom);
        bus.hb_len = CW'($urandom);
        bus.vb_len = CW'($urandom);
        bus.act_px = CW'($urandom);
        bus.act_ln = CW'($urandom);
      end
    end
    swp = bf;
    if (bf) mb = !mb;
`ifdef UNDERRUN_CNT_EN
    else if (ur != 8'hff) ur = ur + 8'd1;
`endif
  endtask
  initial begin
    vec_t c;
    int len, rds;
    vt[0] = '{2, 1, 4, 2, 54, 24};
    vt[1] = '{1, 2, 1, 0, 12, 0};
    vt[2] = '{0, 0, 0, 0, 3, 0};
    vt[3] = '{0, 0, 2, 2, 12, 12};
    vt[4] = '{3, 0, 0, 2, 18, 0};
    vt[5] = '{1, 1, 3, 1, 24, 9};
    vt[6] = '{5, 1, 4, 2, 81, 24};
    bus.cs_display = 1'b0;
    bus.back_full = 1'b0;
    bus.hb_len = '0;
    bus.vb_len = '0;
    bus.act_px = '0;
    bus.act_ln = '0;
    mb = 0;
    swp = 0;
    ur = '0;
    #12 chk("reset", pk(0, 0, 3'd0, 0, 0, 17'd0, 0, 0, 0, 0, 8'd0), act);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) idle_chk("idle_after_reset");
    for (int i = 0; i < 7; i++) begin
      frame(vt[i], 1'(i), 1'b0, len, rds);
      chkv($sformatf("len[%0d]", i), len, vt[i].len);
      chkv($sformatf("rd_cycles[%0d]", i), rds, vt[i].rd);
      to_idle($sformatf("idle[%0d]", i));
    end
    frame(vt[0], 1'b0, 1'b1, len, rds);
    frame(vt[0], 1'b1, 1'b1, len, rds);
    frame(vt[0], 1'b0, 1'b1, len, rds);
    chkv("underrun_frame_len", len, 54);
    frame(vt[6], 1'b0, 1'b0, len, rds);
    chkv("hb5_frame_len", len, 81);
    to_idle("idle_after_stream");
    for (int i = 0; i < 25; i++) begin
      c.hb = $urandom_range(0, 4);
      c.vb = $urandom_range(0, 4);
      c.ap = $urandom_range(0, 4);
      c.al = $urandom_range(0, 4);
      c.len = 0;
      c.rd = 0;
      frame(c, 1'($urandom), 1'(i % 3 != 0), len, rds);
      if (i % 3 == 0) to_idle($sformatf("rand_idle[%0d]", i));
    end
    frame(vt[0], 1'b1, 1'b1, len, rds);
    bus.hb_len = 10'd2;
    bus.vb_len = 10'd1;
    bus.act_px = 10'd4;
    bus.act_ln = 10'd2;
    bus.cs_display = 1'b1;
    bus.back_full = 1'b0;
    repeat (31) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("reset_mid_frame", pk(0, 0, 3'd0, 0, 0, 17'd0, 0, 0, 0, 0, 8'd0), act);
    mb = 0;
    swp = 0;
    ur = '0;
    @(negedge clk);
    bus.cs_display = 1'b0;
    reset = 1'b0;
    idle_chk("idle_after_mid_reset");
    @(negedge clk) idle_chk("idle_after_mid_reset_hold");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
